// File: rtl/multi_cycle_alu.sv
// multi_cycle_alu
// Execute-stage ALU: single-cycle logic/arithmetic ops with a registered
// result, plus an iterative multiply/divide unit (shift-add multiply,
// restoring divide) that writes the HI/LO registers.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, op, a, b   issue strobe with op code and operands
//   busy              multiply/divide in progress
//   valid             one-cycle pulse when r/flags or hi/lo were updated
//   r, zero, ovf, dz  registered result and flags
//   hi, lo            HI/LO registers (remainder/quotient, product halves)
//
// Handshake: an issue is taken on a rising edge where start=1 and busy=0.
// While busy=1, start/op/a/b are ignored and nothing is queued. Every
// accepted issue produces exactly one valid pulse: one cycle after issue
// for single-cycle ops, WIDTH+1 cycles after issue for mult/div. A reset
// drops any in-flight op, and that op never pulses valid.
module multi_cycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state, state_nx;

  // Control strobes from the output process.
  logic load_single, load_iter, step, finish;

  // Iterative datapath registers.
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;       // {acc, multiplier} or {remainder, quotient}
  logic [WIDTH-1:0]   m_reg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_hold;  // raw dividend, returned in hi on divide by zero
  logic               is_div, neg_q, neg_r, bzero;

  // 1000..1011 are the iterative codes.
  logic iter_op;
  assign iter_op = op[3] & ~op[2];

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && iter_op) state_nx = S_RUN;
      S_RUN:   if (cnt == CW'(1))    state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- outputs / control ----------------
  always_comb begin
    busy        = 1'b0;
    load_single = 1'b0;
    load_iter   = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE: begin
        load_single = start & ~iter_op;
        load_iter   = start & iter_op;
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      S_FIN: begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] sum_ab, dif_ab, res_single;
  logic             ovf_add, ovf_sub, ovf_single;

  always_comb begin
    sum_ab  = a + b;
    dif_ab  = a - b;
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ab[WIDTH-1] != a[WIDTH-1]);
    res_single = '0;
    ovf_single = 1'b0;
    case (op)
      4'b0000: res_single = a & b;
      4'b0001: res_single = a | b;
      4'b0010: begin res_single = sum_ab; ovf_single = ovf_add; end
      4'b0110: begin res_single = dif_ab; ovf_single = ovf_sub; end
      // Difference sign is wrong exactly when the subtraction overflowed.
      4'b0111: res_single = {{(WIDTH-1){1'b0}}, dif_ab[WIDTH-1] ^ ovf_sub};
      4'b1100: res_single = ~(a | b);
      4'b1101: res_single = hi;
      4'b1110: res_single = lo;
      default: res_single = '0;
    endcase
  end

  // ---------------- operand magnitudes at issue ----------------
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sgn_op = ~op[0];
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;
  end

  // ---------------- one iteration ----------------
  logic [WIDTH:0]     mul_sum, div_sh, div_df;
  logic [2*WIDTH-1:0] p_mul, p_div;

  always_comb begin
    // Multiply: add multiplicand into the upper half if the current
    // multiplier bit is set, then shift the whole pair right by one.
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m_reg} : '0);
    p_mul   = {mul_sum, p[WIDTH-1:1]};
    // Divide: shift next dividend bit into the remainder and try to
    // subtract the divisor; keep the difference only if it is non-negative.
    div_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_df  = div_sh - {1'b0, m_reg};
    if (div_df[WIDTH]) p_div = {div_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
    else               p_div = {div_df[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  end

  // ---------------- final sign correction ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               dz_n;

  always_comb begin
    prod_fix = neg_q ? -p : p;
    dz_n     = 1'b0;
    if (is_div) begin
      lo_n = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
      hi_n = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      if (bzero) begin
        lo_n = '1;
        hi_n = a_hold;
        dz_n = 1'b1;
      end
    end else begin
      hi_n = prod_fix[2*WIDTH-1:WIDTH];
      lo_n = prod_fix[WIDTH-1:0];
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r      <= '0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      valid  <= 1'b0;
      cnt    <= '0;
      p      <= '0;
      m_reg  <= '0;
      a_hold <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bzero  <= 1'b0;
    end else begin
      valid <= load_single | finish;
      if (load_single) begin
        r    <= res_single;
        zero <= (res_single == '0);
        ovf  <= ovf_single;
        dz   <= 1'b0;
      end
      if (load_iter) begin
        // op[1] distinguishes divide (dividend in p) from multiply
        // (multiplier in p).
        p      <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
        m_reg  <= op[1] ? b_mag : a_mag;
        a_hold <= a;
        is_div <= op[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        bzero  <= (b == '0);
        cnt    <= CW'(WIDTH);
      end
      if (step) begin
        p   <= is_div ? p_div : p_mul;
        cnt <= cnt - CW'(1);
      end
      if (finish) begin
        hi <= hi_n;
        lo <= lo_n;
        dz <= dz_n;
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Bench for multi_cycle_alu: a 32-bit and an 8-bit instance share clock and
// reset. A cycle-level reference model (plain integer arithmetic plus a
// countdown for iterative latency) is compared against both instances every
// cycle; directed scenarios add literal expectations.
module tb_multi_cycle_alu;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic        start32, busy32, valid32, zero32, ovf32, dz32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, r32, hi32, lo32;

  logic        start8, busy8, valid8, zero8, ovf8, dz8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, r8, hi8, lo8;

  multi_cycle_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .valid(valid32), .r(r32), .zero(zero32), .ovf(ovf32),
    .dz(dz32), .hi(hi32), .lo(lo32)
  );

  multi_cycle_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .valid(valid8), .r(r8), .zero(zero8), .ovf(ovf8),
    .dz(dz8), .hi(hi8), .lo(lo8)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models the 32-bit instance, index 1 the 8-bit one.
  longint unsigned m_r[2], m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  bit              m_zero[2], m_ovf[2], m_dz[2], m_valid[2], m_busy[2], p_dz[2];
  int              remain[2];

  function automatic longint sx(input longint unsigned x, input int w);
    longint t;
    t = x << (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic model_step(input int i, input int w, input bit rs, input bit st,
                            input logic [3:0] o, input longint unsigned x,
                            input longint unsigned y);
    longint unsigned mask, res, ut;
    longint          sa, sb, t;
    mask = (64'd1 << w) - 64'd1;
    sa = sx(x, w);
    sb = sx(y, w);
    if (rs) begin
      m_r[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_zero[i] = 1'b1; m_ovf[i] = 1'b0;
      m_dz[i] = 1'b0; m_valid[i] = 1'b0; m_busy[i] = 1'b0; remain[i] = 0;
      return;
    end
    m_valid[i] = 1'b0;
    if (remain[i] > 0) begin
      remain[i]--;
      if (remain[i] == 0) begin
        m_hi[i] = p_hi[i]; m_lo[i] = p_lo[i]; m_dz[i] = p_dz[i];
        m_valid[i] = 1'b1; m_busy[i] = 1'b0;
      end
    end else if (st) begin
      if (o[3:2] == 2'b10) begin
        p_dz[i] = 1'b0;
        case (o[1:0])
          2'b00: begin t = sa * sb; ut = t; p_hi[i] = (ut >> w) & mask; p_lo[i] = ut & mask; end
          2'b01: begin ut = x * y; p_hi[i] = (ut >> w) & mask; p_lo[i] = ut & mask; end
          default: begin
            if (y == 0) begin
              p_lo[i] = mask; p_hi[i] = x; p_dz[i] = 1'b1;
            end else if (o[0] == 1'b0) begin
              t = sa / sb; ut = t; p_lo[i] = ut & mask;
              t = sa % sb; ut = t; p_hi[i] = ut & mask;
            end else begin
              p_lo[i] = x / y; p_hi[i] = x % y;
            end
          end
        endcase
        remain[i] = w + 1;
        m_busy[i] = 1'b1;
      end else begin
        m_ovf[i] = 1'b0;
        case (o)
          4'b0000: res = x & y;
          4'b0001: res = x | y;
          4'b0010: begin t = sa + sb; ut = t; res = ut & mask; m_ovf[i] = (t != sx(res, w)); end
          4'b0110: begin t = sa - sb; ut = t; res = ut & mask; m_ovf[i] = (t != sx(res, w)); end
          4'b0111: res = (sa < sb) ? 64'd1 : 64'd0;
          4'b1100: res = ~(x | y) & mask;
          4'b1101: res = m_hi[i];
          4'b1110: res = m_lo[i];
          default: res = 0;
        endcase
        m_r[i] = res; m_zero[i] = (res == 0); m_dz[i] = 1'b0; m_valid[i] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 32, rst, start32, op32, {32'h0, a32}, {32'h0, b32});
    model_step(1, 8,  rst, start8,  op8,  {56'h0, a8},  {56'h0, b8});
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      cmp("valid32", 64'(valid32), 64'(m_valid[0]));
      cmp("busy32",  64'(busy32),  64'(m_busy[0]));
      cmp("r32",     64'(r32),     m_r[0]);
      cmp("zero32",  64'(zero32),  64'(m_zero[0]));
      cmp("ovf32",   64'(ovf32),   64'(m_ovf[0]));
      cmp("dz32",    64'(dz32),    64'(m_dz[0]));
      cmp("hi32",    64'(hi32),    m_hi[0]);
      cmp("lo32",    64'(lo32),    m_lo[0]);
      cmp("valid8",  64'(valid8),  64'(m_valid[1]));
      cmp("busy8",   64'(busy8),   64'(m_busy[1]));
      cmp("r8",      64'(r8),      m_r[1]);
      cmp("zero8",   64'(zero8),   64'(m_zero[1]));
      cmp("ovf8",    64'(ovf8),    64'(m_ovf[1]));
      cmp("dz8",     64'(dz8),     64'(m_dz[1]));
      cmp("hi8",     64'(hi8),     m_hi[1]);
      cmp("lo8",     64'(lo8),     m_lo[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input bit st, input logic [3:0] o,
                       input logic [63:0] x, input logic [63:0] y);
    if (sel == 32) begin
      start32 = st; op32 = o; a32 = x[31:0]; b32 = y[31:0];
    end else begin
      start8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one issue and return at the negedge after the issue edge.
  task automatic issue(input int sel, input logic [3:0] o,
                       input logic [63:0] x, input logic [63:0] y);
    drive(sel, 1'b1, o, x, y);
    tick();
    drive(sel, 1'b0, o, x, y);
  endtask

  // Count negedges with busy high; returns at the first negedge with busy low.
  task automatic wait_done(input int sel, output int n);
    n = 0;
    while (((sel == 32) ? busy32 : busy8) && n < 200) begin
      n++;
      tick();
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_done: busy still high after %0d cycles", n);
    end
  endtask

  function automatic logic [63:0] rand_operand(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return mask;
      2: return 64'd1 << (w - 1);
      3: return mask >> 1;
      default: return {32'h0, $urandom()} & mask;
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    drive(32, 1'b0, 4'h0, 64'h0, 64'h0);
    drive(8,  1'b0, 4'h0, 64'h0, 64'h0);
    repeat (2) tick();
    rst = 1'b0;
    cmp("rst_r", 64'(r32), 64'h0);
    cmp("rst_zero", 64'(zero32), 64'h1);
    cmp("rst_busy", 64'(busy32), 64'h0);

    // Reset during RUN of a MULT, with a start dropped under reset.
    issue(32, 4'b1000, 64'd3, 64'd5);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    drive(32, 1'b1, 4'b0010, 64'd1, 64'd1);
    tick();
    rst = 1'b0;
    drive(32, 1'b0, 4'b0010, 64'd1, 64'd1);
    cmp("abort_busy", 64'(busy32), 64'h0);
    cmp("abort_valid", 64'(valid32), 64'h0);
    cmp("abort_hi", 64'(hi32), 64'h0);
    cmp("abort_lo", 64'(lo32), 64'h0);
    cmp("abort_r", 64'(r32), 64'h0);
    cmp("abort_zero", 64'(zero32), 64'h1);
    n = 0;
    repeat (40) begin
      tick();
      if (valid32) n++;
    end
    cmp("abort_no_valid", 64'(n), 64'd0);

    // Logic / arithmetic / overflow.
    issue(32, 4'b0010, 64'h7FFFFFFF, 64'd1);
    cmp("add_valid", 64'(valid32), 64'h1);
    cmp("add_r", 64'(r32), 64'h80000000);
    cmp("add_ovf", 64'(ovf32), 64'h1);
    issue(32, 4'b0110, 64'h80000000, 64'd1);
    cmp("sub_r", 64'(r32), 64'h7FFFFFFF);
    cmp("sub_ovf", 64'(ovf32), 64'h1);
    issue(32, 4'b0111, 64'h80000000, 64'h7FFFFFFF);
    cmp("slt_r", 64'(r32), 64'h1);
    issue(32, 4'b1100, 64'h0, 64'h0);
    cmp("nor_r", 64'(r32), 64'hFFFFFFFF);
    cmp("nor_zero", 64'(zero32), 64'h0);

    // Signed multiply with an ignored mid-RUN start.
    issue(32, 4'b1000, 64'hFFFFFFFD, 64'd7);
    n = 0;
    while (busy32 && n < 200) begin
      if (n == 10) drive(32, 1'b1, 4'b0010, 64'd1, 64'd1);
      if (n == 11) drive(32, 1'b0, 4'b0010, 64'd1, 64'd1);
      n++;
      tick();
    end
    cmp("mult_busy_cycles", 64'(n), 64'd33);
    cmp("mult_valid", 64'(valid32), 64'h1);
    cmp("mult_hi", 64'(hi32), 64'hFFFFFFFF);
    cmp("mult_lo", 64'(lo32), 64'hFFFFFFEB);
    cmp("mult_r_kept", 64'(r32), 64'hFFFFFFFF);
    tick();
    cmp("mult_valid_pulse", 64'(valid32), 64'h0);

    // Divide and divide-by-zero.
    issue(32, 4'b1010, 64'hFFFFFFF9, 64'd2);
    wait_done(32, n);
    cmp("div_lo", 64'(lo32), 64'hFFFFFFFD);
    cmp("div_hi", 64'(hi32), 64'hFFFFFFFF);
    cmp("div_dz", 64'(dz32), 64'h0);
    issue(32, 4'b1011, 64'd5, 64'd0);
    wait_done(32, n);
    cmp("divz_lo", 64'(lo32), 64'hFFFFFFFF);
    cmp("divz_hi", 64'(hi32), 64'd5);
    cmp("divz_dz", 64'(dz32), 64'h1);
    issue(32, 4'b1010, 64'h80000000, 64'hFFFFFFFF);
    wait_done(32, n);
    cmp("divmin_lo", 64'(lo32), 64'h80000000);
    cmp("divmin_hi", 64'(hi32), 64'h0);

    // MULTU then MFHI / MFLO back to back from the valid cycle.
    issue(32, 4'b1001, 64'hFFFFFFFF, 64'hFFFFFFFF);
    wait_done(32, n);
    drive(32, 1'b1, 4'b1101, 64'h0, 64'h0);
    tick();
    drive(32, 1'b1, 4'b1110, 64'h0, 64'h0);
    cmp("mfhi_r", 64'(r32), 64'hFFFFFFFE);
    cmp("mfhi_valid", 64'(valid32), 64'h1);
    tick();
    drive(32, 1'b0, 4'b1110, 64'h0, 64'h0);
    cmp("mflo_r", 64'(r32), 64'h1);
    cmp("mflo_valid", 64'(valid32), 64'h1);

    // Width generality.
    issue(8, 4'b1001, 64'd200, 64'd200);
    wait_done(8, n);
    cmp("w8_busy_cycles", 64'(n), 64'd9);
    cmp("w8_prod", 64'({hi8, lo8}), 64'h9C40);
    issue(8, 4'b1011, 64'd200, 64'd7);
    wait_done(8, n);
    cmp("w8_divu_lo", 64'(lo8), 64'd28);
    cmp("w8_divu_hi", 64'(hi8), 64'd4);

    // Randomized traffic on both instances, starts even while busy.
    repeat (1500) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      drive(32, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
            rand_operand(32), rand_operand(32));
      drive(8, ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
            rand_operand(8), rand_operand(8));
    end
    tick();
    rst = 1'b0;
    drive(32, 1'b0, 4'h0, 64'h0, 64'h0);
    drive(8,  1'b0, 4'h0, 64'h0, 64'h0);
    repeat (40) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
